// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs feeding one registered CDB broadcast/cycle.
// Ports: clk, rst_n, branch_flush, fu_valid/fu_ready/fu_preg/fu_rob/fu_data
//   (FU side), cdb_valid/cdb_preg_index/cdb_rob_index/cdb_data/cdb_src (bus).
// Build option: CDB_FIXED_PRIO_EN selects fixed priority (lowest FU wins)
//   instead of the default round-robin.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 4,
  parameter int DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       branch_flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*PREG_W-1:0]   fu_preg,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  output logic                       cdb_valid,
  output logic [PREG_W-1:0]          cdb_preg_index,
  output logic [ROB_W-1:0]           cdb_rob_index,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(NUM_FU)-1:0]  cdb_src
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_FU);

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } res_t;

  res_t [NUM_FU-1:0]  head;
  logic [NUM_FU-1:0]  empty;
  logic [NUM_FU-1:0]  full;
  logic [NUM_FU-1:0]  push;
  logic [NUM_FU-1:0]  pop;
  logic               any;
  logic [SW-1:0]      win;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    res_t        mem [FIFO_DEPTH];
    res_t        din;

    assign din.preg = fu_preg[i*PREG_W +: PREG_W];
    assign din.rob  = fu_rob[i*ROB_W +: ROB_W];
    assign din.data = fu_data[i*DATA_W +: DATA_W];

    // Extra MSB tells a full FIFO from an empty one at equal indices.
    assign empty[i] = (wptr == rptr);
    assign full[i]  = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);

    // Ready comes from registered state only; a same-cycle pop
    // does not free a slot until the next cycle.
    assign push[i] = fu_valid[i] & ~full[i] & ~branch_flush;
    assign pop[i]  = any & (win == SW'(i)) & ~branch_flush;
    assign head[i] = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
      end else if (branch_flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push[i]) wptr <= wptr + 1'b1;
        if (pop[i])  rptr <= rptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push[i]) mem[wptr[AW-1:0]] <= din;
    end
  end

  assign fu_ready = ~full;

`ifdef CDB_FIXED_PRIO_EN

  // Scan high to low so the lowest non-empty index is left in win.
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (!empty[k]) begin
        any = 1'b1;
        win = SW'(k);
      end
    end
  end

`else

  logic [SW-1:0] rr_ptr;
  logic [SW:0]   idx;

  // First non-empty FIFO at or after rr_ptr, wrapping at NUM_FU.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(NUM_FU))
        idx = idx - (SW+1)'(NUM_FU);
      if (!any && !empty[idx[SW-1:0]]) begin
        any = 1'b1;
        win = idx[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (!branch_flush && any) begin
      if (win == SW'(NUM_FU - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= win + SW'(1);
    end
  end

`endif

  // Broadcast register; payload fields hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid      <= 1'b0;
      cdb_preg_index <= '0;
      cdb_rob_index  <= '0;
      cdb_data       <= '0;
      cdb_src        <= '0;
    end else if (branch_flush) begin
      cdb_valid <= 1'b0;
    end else if (any) begin
      cdb_valid      <= 1'b1;
      cdb_preg_index <= head[win].preg;
      cdb_rob_index  <= head[win].rob;
      cdb_data       <= head[win].data;
      cdb_src        <= win;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random traffic against a queue-based model
// of the CDB arbiter (per-FU FIFOs, one broadcast per cycle).
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int PW = 6;
  localparam int RW = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            branch_flush = 1'b0;
  logic [N-1:0]    fu_valid = '0;
  logic [N-1:0]    fu_ready;
  logic [N*PW-1:0] fu_preg = '0;
  logic [N*RW-1:0] fu_rob = '0;
  logic [N*DW-1:0] fu_data = '0;
  logic            cdb_valid;
  logic [PW-1:0]   cdb_preg_index;
  logic [RW-1:0]   cdb_rob_index;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;

  cdb_arbiter #(
    .NUM_FU(N), .FIFO_DEPTH(D), .PREG_W(PW), .ROB_W(RW), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .branch_flush(branch_flush),
    .fu_valid(fu_valid),
    .fu_ready(fu_ready),
    .fu_preg(fu_preg),
    .fu_rob(fu_rob),
    .fu_data(fu_data),
    .cdb_valid(cdb_valid),
    .cdb_preg_index(cdb_preg_index),
    .cdb_rob_index(cdb_rob_index),
    .cdb_data(cdb_data),
    .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q [N][$];
  int            rr;
  logic          ev;
  logic [PW-1:0] ep;
  logic [RW-1:0] er;
  logic [DW-1:0] ed;
  logic [SW-1:0] es;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    rr = 0;
    ev = 1'b0;
    ep = '0;
    er = '0;
    ed = '0;
    es = '0;
  endtask

  task automatic set_fu(input int i, input logic [PW-1:0] p,
                        input logic [RW-1:0] r, input logic [DW-1:0] d);
    fu_valid[i] = 1'b1;
    fu_preg[i*PW +: PW] = p;
    fu_rob[i*RW +: RW] = r;
    fu_data[i*DW +: DW] = d;
  endtask

  // One clock: check ready, predict the edge, advance, check the bus.
  task automatic cycle();
    logic [N-1:0] rdy;
    logic [N-1:0] v;
    logic         fl;
    ent_t         in_e [N];
    int           w;
    int           start;
    ent_t         e;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (q[i].size() < D);
      in_e[i].p = fu_preg[i*PW +: PW];
      in_e[i].r = fu_rob[i*RW +: RW];
      in_e[i].d = fu_data[i*DW +: DW];
    end
    v = fu_valid;
    fl = branch_flush;
    chk("ready", {60'd0, fu_ready}, {60'd0, rdy});
`ifdef CDB_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (w < 0 && q[j].size() > 0) w = j;
    end
    @(posedge clk);
    #1;
    if (fl) begin
      for (int i = 0; i < N; i++) q[i].delete();
      ev = 1'b0;
    end else begin
      if (w >= 0) begin
        e = q[w].pop_front();
        ev = 1'b1;
        ep = e.p;
        er = e.r;
        ed = e.d;
        es = SW'(w);
        rr = (w + 1) % N;
      end else begin
        ev = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (v[i] && rdy[i]) q[i].push_back(in_e[i]);
    end
    chk("valid", {63'd0, cdb_valid}, {63'd0, ev});
    chk("preg", {58'd0, cdb_preg_index}, {58'd0, ep});
    chk("rob", {60'd0, cdb_rob_index}, {60'd0, er});
    chk("data", {32'd0, cdb_data}, {32'd0, ed});
    chk("src", {62'd0, cdb_src}, {62'd0, es});
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset();
    fu_valid = '0;
    branch_flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
    chk("rst_ready", {60'd0, fu_ready}, 64'hf);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fu_valid = '0;
    branch_flush = 1'b0;
    cycle();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single result from FU2.
    set_fu(2, 6'd5, 4'd3, 32'hDEAD);
    cycle();
    idle();
    chk("single_valid", {63'd0, cdb_valid}, 64'd1);
    chk("single_preg", {58'd0, cdb_preg_index}, 64'd5);
    chk("single_rob", {60'd0, cdb_rob_index}, 64'd3);
    chk("single_data", {32'd0, cdb_data}, 64'hDEAD);
    chk("single_src", {62'd0, cdb_src}, 64'd2);
    idle();
    chk("single_end", {63'd0, cdb_valid}, 64'd0);

    // Contention from rr_ptr = 0.
    do_reset();
    for (int i = 0; i < N; i++)
      set_fu(i, PW'(i + 1), RW'(i + 8), DW'(32'hA000 + i));
    cycle();
    idle();
    for (int s = 0; s < N; s++) begin
      chk("cont_valid", {63'd0, cdb_valid}, 64'd1);
      chk("cont_src", {62'd0, cdb_src}, 64'(s));
      idle();
    end

    // Flush with three buffered results and a concurrent push.
    do_reset();
    set_fu(0, 6'd1, 4'd1, 32'h11);
    set_fu(1, 6'd2, 4'd2, 32'h22);
    set_fu(2, 6'd3, 4'd3, 32'h33);
    cycle();
    fu_valid = '0;
    set_fu(0, 6'd4, 4'd4, 32'h44);
    branch_flush = 1'b1;
    cycle();
    branch_flush = 1'b0;
    fu_valid = '0;
    chk("flush_valid", {63'd0, cdb_valid}, 64'd0);
    chk("flush_ready", {60'd0, fu_ready}, 64'hf);
    for (int c = 0; c < 4; c++) begin
      idle();
      chk("flush_quiet", {63'd0, cdb_valid}, 64'd0);
    end

    // preg 0 still broadcasts.
    set_fu(1, 6'd0, 4'd9, 32'h1234);
    cycle();
    idle();
    chk("p0_valid", {63'd0, cdb_valid}, 64'd1);
    chk("p0_preg", {58'd0, cdb_preg_index}, 64'd0);
    chk("p0_rob", {60'd0, cdb_rob_index}, 64'd9);

    // Reset in the middle of a broadcast.
    do_reset();

    // Random traffic, flushes and backpressure.
    for (int c = 0; c < 3000; c++) begin
      fu_valid = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 6) begin
          set_fu(i,
                 ($urandom_range(0, 7) == 0) ? PW'(0) : PW'($urandom),
                 RW'($urandom), DW'($urandom));
        end
      end
      branch_flush = ($urandom_range(0, 39) == 0);
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    for (int c = 0; c < 12; c++) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
